// File: rtl/silencer_pkg.sv
// Shared sizes, FSM state type and the signed duty slew clamp for the silencer.
package silencer_pkg;

  localparam int unsigned WIDTH        = 13;
  localparam int unsigned DEPTH        = 249;
  localparam int unsigned DW           = WIDTH + 1;
  localparam int unsigned IDX_W        = $clog2(DEPTH);
  localparam int unsigned PIPE_LATENCY = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_e;

  // Two's-complement DW-bit difference limited to +/-step.
  function automatic logic [DW-1:0] step_clamp(input logic [DW-1:0]    diff,
                                               input logic [WIDTH-1:0] step);
    logic [DW-1:0] mag;
    logic [DW-1:0] lim;
    mag = diff[DW-1] ? DW'(-diff) : diff;
    lim = {1'b0, step};
    if (mag <= lim) begin
      step_clamp = diff;
    end else begin
      step_clamp = diff[DW-1] ? DW'(-lim) : lim;
    end
  endfunction

endpackage

// File: rtl/silencer_step_unit.sv
// One-element slew pipeline: S1 registers differences, S2 (combinational here,
// registered by the caller's output array) applies the step with phase wrap.
module silencer_step_unit
  import silencer_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             valid_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [WIDTH-1:0] cur_duty_i,
  input  logic [WIDTH-1:0] tgt_duty_i,
  input  logic [WIDTH-1:0] cur_phase_i,
  input  logic [WIDTH-1:0] tgt_phase_i,
  input  logic [WIDTH-1:0] cycle_i,
  input  logic [WIDTH-1:0] step_i,
  input  logic             bypass_i,
  output logic             wr_en_o,
  output logic [IDX_W-1:0] wr_idx_o,
  output logic [WIDTH-1:0] duty_c_o,
  output logic [WIDTH-1:0] phase_c_o
);

  logic [WIDTH-1:0] cur_red_c;
  logic [WIDTH-1:0] tgt_red_c;
  logic [WIDTH-1:0] pdiff_c;
  logic [DW-1:0]    ddiff_c;

  logic             valid_q;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] cur_duty_q;
  logic [WIDTH-1:0] tgt_duty_q;
  logic [DW-1:0]    ddiff_q;
  logic [WIDTH-1:0] cur_ph_q;
  logic [WIDTH-1:0] tgt_ph_q;
  logic [WIDTH-1:0] pdiff_q;
  logic [WIDTH-1:0] cycle_q;
  logic [WIDTH-1:0] step_q;
  logic             bypass_q;

  logic             fwd_c;
  logic [WIDTH-1:0] dist_c;
  logic [DW-1:0]    sum_c;

  // S1: reduce phases into [0,cycle) and form forward phase distance mod cycle.
  always_comb begin
    cur_red_c = '0;
    tgt_red_c = '0;
    if (cycle_i != '0) begin
      cur_red_c = cur_phase_i % cycle_i;
      tgt_red_c = tgt_phase_i % cycle_i;
    end
    pdiff_c = (tgt_red_c >= cur_red_c) ? tgt_red_c - cur_red_c
                                       : tgt_red_c + cycle_i - cur_red_c;
    ddiff_c = {1'b0, tgt_duty_i} - {1'b0, cur_duty_i};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) begin
        idx_q      <= idx_i;
        cur_duty_q <= cur_duty_i;
        tgt_duty_q <= tgt_duty_i;
        ddiff_q    <= ddiff_c;
        cur_ph_q   <= cur_red_c;
        tgt_ph_q   <= tgt_red_c;
        pdiff_q    <= pdiff_c;
        cycle_q    <= cycle_i;
        step_q     <= step_i;
        bypass_q   <= bypass_i;
      end
    end
  end

  // S2: half-cycle tie goes forward; single wrap correction suffices since step < dist < cycle.
  always_comb begin
    duty_c_o  = bypass_q ? tgt_duty_q
                         : WIDTH'(DW'(cur_duty_q) + step_clamp(ddiff_q, step_q));
    fwd_c     = pdiff_q <= (cycle_q >> 1);
    dist_c    = fwd_c ? pdiff_q : cycle_q - pdiff_q;
    sum_c     = '0;
    phase_c_o = tgt_ph_q;
    if (cycle_q == '0) begin
      phase_c_o = '0;
    end else if (!bypass_q && (pdiff_q != '0) && (dist_c > step_q)) begin
      if (fwd_c) begin
        sum_c     = DW'(cur_ph_q) + DW'(step_q);
        phase_c_o = (sum_c >= DW'(cycle_q)) ? WIDTH'(sum_c - DW'(cycle_q)) : WIDTH'(sum_c);
      end else begin
        phase_c_o = (cur_ph_q >= step_q) ? cur_ph_q - step_q
                                         : cur_ph_q + cycle_q - step_q;
      end
    end
  end

  assign wr_en_o  = valid_q;
  assign wr_idx_o = idx_q;

endmodule

// File: rtl/silencer.sv
// Slew limiter between modulator and pulse-width stage: FSM, index walk, input snapshot.
// Optional SILENCER_BYPASS_EN adds bypass_i (copy targets directly, same timing).
module silencer
  import silencer_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] cycle_i [DEPTH],
  input  logic [WIDTH-1:0] step_i,
  input  logic [WIDTH-1:0] duty_i  [DEPTH],
  input  logic [WIDTH-1:0] phase_i [DEPTH],
  input  logic             start_i,
`ifdef SILENCER_BYPASS_EN
  input  logic             bypass_i,
`endif
  output logic [WIDTH-1:0] duty_o  [DEPTH],
  output logic [WIDTH-1:0] phase_o [DEPTH],
  output logic             done_o
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;
  logic             snap_en_c;

  logic [WIDTH-1:0] cyc_snap_q   [DEPTH];
  logic [WIDTH-1:0] duty_snap_q  [DEPTH];
  logic [WIDTH-1:0] phase_snap_q [DEPTH];
  logic [WIDTH-1:0] step_snap_q;
  logic             bypass_s;

  logic [WIDTH-1:0] duty_q  [DEPTH];
  logic [WIDTH-1:0] phase_q [DEPTH];

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [WIDTH-1:0] duty_c;
  logic [WIDTH-1:0] phase_c;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // idx walks elements in RUN and counts pipeline drain cycles in FLUSH.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    snap_en_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d   = RUN;
          idx_d     = '0;
          snap_en_c = 1'b1;
        end
      end
      RUN: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_W'(DEPTH - 1)) begin
          state_d = FLUSH;
          idx_d   = '0;
        end
      end
      FLUSH: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_W'(PIPE_LATENCY - 1)) begin
          state_d = DONE;
          idx_d   = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (snap_en_c) begin
      cyc_snap_q   <= cycle_i;
      duty_snap_q  <= duty_i;
      phase_snap_q <= phase_i;
      step_snap_q  <= step_i;
    end
  end

`ifdef SILENCER_BYPASS_EN
  logic bypass_q;
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      bypass_q <= 1'b0;
    end else if (snap_en_c) begin
      bypass_q <= bypass_i;
    end
  end
  assign bypass_s = bypass_q;
`else
  assign bypass_s = 1'b0;
`endif

  silencer_step_unit u_step_unit (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .valid_i     (state_q == RUN),
    .idx_i       (idx_q),
    .cur_duty_i  (duty_q[idx_q]),
    .tgt_duty_i  (duty_snap_q[idx_q]),
    .cur_phase_i (phase_q[idx_q]),
    .tgt_phase_i (phase_snap_q[idx_q]),
    .cycle_i     (cyc_snap_q[idx_q]),
    .step_i      (step_snap_q),
    .bypass_i    (bypass_s),
    .wr_en_o     (wr_en),
    .wr_idx_o    (wr_idx),
    .duty_c_o    (duty_c),
    .phase_c_o   (phase_c)
  );

  // Output arrays form the S2 register; each element is written once per pass.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        duty_q[i]  <= '0;
        phase_q[i] <= '0;
      end
    end else if (wr_en) begin
      duty_q[wr_idx]  <= duty_c;
      phase_q[wr_idx] <= phase_c;
    end
  end

  assign duty_o  = duty_q;
  assign phase_o = phase_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_silencer.sv
// Directed bench for silencer: pass-level behavioural model checked every cycle,
// plus literal expectations for ramps, wraps, ties, freeze, ignore and reset abort.
module tb_silencer;
  import silencer_pkg::*;

  localparam int ND = int'(DEPTH);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] cyc_in   [DEPTH];
  logic [WIDTH-1:0] duty_in  [DEPTH];
  logic [WIDTH-1:0] phase_in [DEPTH];
  logic [WIDTH-1:0] duty_out [DEPTH];
  logic [WIDTH-1:0] phase_out[DEPTH];
  logic             done;

  int checks = 0;
  int errors = 0;

  silencer dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .cycle_i (cyc_in),
    .step_i  (step),
    .duty_i  (duty_in),
    .phase_i (phase_in),
    .start_i (start),
`ifdef SILENCER_BYPASS_EN
    .bypass_i(1'b0),
`endif
    .duty_o  (duty_out),
    .phase_o (phase_out),
    .done_o  (done)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  // Pass-level model: targets computed at START, element i lands 2 edges after its RUN slot.
  function automatic int slew_duty(input int cur, input int tgt, input int st);
    int d;
    d = tgt - cur;
    if (((d < 0) ? -d : d) <= st) return tgt;
    return (d > 0) ? cur + st : cur - st;
  endfunction

  function automatic int slew_phase(input int cur, input int tgt, input int cy, input int st);
    int cr, tr, d;
    if (cy == 0) return 0;
    cr = cur % cy;
    tr = tgt % cy;
    d  = (tr - cr + cy) % cy;
    if (d == 0) return cr;
    if (d <= cy / 2) return (d <= st) ? tr : (cr + st) % cy;
    return ((cy - d) <= st) ? tr : (cr - st + cy) % cy;
  endfunction

  int m_duty [DEPTH];
  int m_phase[DEPTH];
  int n_duty [DEPTH];
  int n_phase[DEPTH];
  int edge_cnt = 0;
  int t0 = 0;
  bit busy = 1'b0;
  bit m_done = 1'b0;
  bit armed = 1'b0;

  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    if (!rst_n) begin
      for (int i = 0; i < ND; i++) begin
        m_duty[i]  <= 0;
        m_phase[i] <= 0;
      end
      busy   <= 1'b0;
      m_done <= 1'b0;
      armed  <= 1'b1;
    end else begin
      m_done <= busy && (edge_cnt == t0 + ND + 3);
      if (busy) begin
        for (int i = 0; i < ND; i++) begin
          if (edge_cnt == t0 + i + 2) begin
            m_duty[i]  <= n_duty[i];
            m_phase[i] <= n_phase[i];
          end
        end
        if (edge_cnt == t0 + ND + 3) busy <= 1'b0;
      end else if (start) begin
        busy <= 1'b1;
        t0   <= edge_cnt;
        for (int i = 0; i < ND; i++) begin
          n_duty[i]  <= slew_duty(m_duty[i], int'(duty_in[i]), int'(step));
          n_phase[i] <= slew_phase(m_phase[i], int'(phase_in[i]), int'(cyc_in[i]), int'(step));
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    int bd, bp;
    if (armed) begin
      bd = -1;
      bp = -1;
      for (int i = ND - 1; i >= 0; i--) begin
        if (int'(duty_out[i]) != m_duty[i]) bd = i;
        if (int'(phase_out[i]) != m_phase[i]) bp = i;
      end
      if (bd >= 0) check($sformatf("model_duty[%0d]", bd), int'(duty_out[bd]), m_duty[bd]);
      else check("model_duty", 0, 0 + bd + 1);
      if (bp >= 0) check($sformatf("model_phase[%0d]", bp), int'(phase_out[bp]), m_phase[bp]);
      else check("model_phase", 0, 0 + bp + 1);
      check("model_done", int'(done), int'(m_done));
    end
  end

  // Runs one pass from a negedge; optional extra START pulse (and input scramble) at offset mid.
  task automatic do_pass(input int mid, output int lat, output int ndone);
    lat   = -1;
    ndone = 0;
    start = 1'b1;
    for (int k = 0; k <= ND + 10; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        ndone++;
        if (lat < 0) lat = k;
      end
      if (k == mid) begin
        start = 1'b1;
        for (int i = 0; i < ND; i++) duty_in[i] = WIDTH'($urandom_range(0, 7999));
      end
    end
  endtask

  int lat, nd;
  int fwd_exp[4];
  int bwd_exp[4];

  initial begin
    fwd_exp = '{4046, 0, 50, 100};
    bwd_exp = '{50, 0, 4046, 4000};
    rst_n = 1'b0;
    start = 1'b0;
    step  = '0;
    for (int i = 0; i < ND; i++) begin
      cyc_in[i]   = WIDTH'(4096);
      duty_in[i]  = '0;
      phase_in[i] = '0;
    end
    repeat (3) @(negedge clk);
    check("reset_duty0", int'(duty_out[0]), 0);
    check("reset_phase5", int'(phase_out[5]), 0);
    check("reset_done", int'(done), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full-range jump: large step reaches every target in one pass.
    step = WIDTH'(8000);
    cyc_in[7] = '0;
    for (int i = 0; i < ND; i++) begin
      duty_in[i]  = WIDTH'($urandom_range(0, 7999));
      phase_in[i] = WIDTH'($urandom_range(0, 8191));
    end
    duty_in[10]  = WIDTH'(7777);
    phase_in[10] = WIDTH'(5000);
    do_pass(-1, lat, nd);
    check("jump_latency", lat, 252);
    check("jump_done_count", nd, 1);
    check("jump_duty10", int'(duty_out[10]), 7777);
    check("jump_phase10", int'(phase_out[10]), 904);
    check("jump_phase7_cycle0", int'(phase_out[7]), 0);
    check("jump_duty200", int'(duty_out[200]), int'(duty_in[200]));
    check("jump_phase3", int'(phase_out[3]), int'(phase_in[3]) % 4096);

    // Position elements for the ramp and wrap scenarios.
    duty_in[0]  = '0;
    phase_in[1] = WIDTH'(3996);
    phase_in[2] = WIDTH'(100);
    phase_in[3] = '0;
    do_pass(-1, lat, nd);

    step = WIDTH'(100);
    duty_in[0] = WIDTH'(1000);
    for (int p = 0; p < 11; p++) begin
      do_pass(-1, lat, nd);
      check($sformatf("ramp_duty_pass%0d", p), int'(duty_out[0]), (p < 10) ? (p + 1) * 100 : 1000);
    end

    step = WIDTH'(50);
    phase_in[1] = WIDTH'(100);
    phase_in[2] = WIDTH'(4000);
    phase_in[3] = WIDTH'(2048);
    for (int p = 0; p < 4; p++) begin
      do_pass(-1, lat, nd);
      check($sformatf("wrap_fwd_pass%0d", p), int'(phase_out[1]), fwd_exp[p]);
      check($sformatf("wrap_bwd_pass%0d", p), int'(phase_out[2]), bwd_exp[p]);
      if (p == 0) check("tie_forward", int'(phase_out[3]), 50);
    end

    // START mid-pass is ignored and inputs changed after START do not leak in.
    do_pass(100, lat, nd);
    check("midstart_latency", lat, 252);
    check("midstart_done_count", nd, 1);
    check("midstart_duty0", int'(duty_out[0]), 1000);

    step = '0;
    duty_in[0]  = WIDTH'(5000);
    phase_in[1] = WIDTH'(2000);
    do_pass(-1, lat, nd);
    check("freeze_latency", lat, 252);
    check("freeze_done_count", nd, 1);
    check("freeze_duty0", int'(duty_out[0]), 1000);
    check("freeze_phase1", int'(phase_out[1]), 100);

    // Reset mid-RUN aborts the pass; the next pass starts from zero.
    step = WIDTH'(8000);
    duty_in[5] = WIDTH'(1234);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_duty5", int'(duty_out[5]), 0);
    check("abort_phase1", int'(phase_out[1]), 0);
    check("abort_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int k = 0; k < ND + 10; k++) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("abort_no_done", nd, 0);
    do_pass(-1, lat, nd);
    check("after_abort_latency", lat, 252);
    check("after_abort_duty5", int'(duty_out[5]), 1234);
    check("after_abort_phase7", int'(phase_out[7]), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
